// File: rtl/uart_sram_ring.sv
`default_nettype none
// ============================================================================
// Module  : uart_sram_ring
// Brief   : Circular SRAM byte buffer between ACIA RX and rate-paced ACIA TX.
// Revision: 1.0 - initial release
// ============================================================================
module uart_sram_ring #(
  parameter int              ADDR_W         = 16,
  parameter int              DEPTH_LOG2     = 12,
  parameter logic [ADDR_W-1:0] BASE         = '0,
  parameter int              TX_PERIOD_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  flush,
  output logic                  acia_cs,
  output logic                  acia_we,
  output logic                  acia_rs,
  output logic [7:0]            acia_din,
  input  logic [7:0]            acia_dout,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [7:0]            sram_dout,
  input  logic [7:0]            sram_din,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [7:0]            ovf_cnt
);

  localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ST_RD   = 4'd1,
    S_ST_WAIT = 4'd2,
    S_RX_RD   = 4'd3,
    S_RX_WAIT = 4'd4,
    S_RX_WR   = 4'd5,
    S_M_RD    = 4'd6,
    S_M_WAIT  = 4'd7,
    S_TX_WR   = 4'd8
  } state_t;

  state_t                r_state, w_next;
  logic                  r_acia_cs, r_acia_we, r_acia_rs, r_sram_we;
  logic [7:0]            r_acia_din, r_sram_dout, r_ovf;
  logic [ADDR_W-1:0]     r_sram_addr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full, r_empty, r_flush_pend;

  logic                  w_cs, w_we, w_rs, w_swe, w_tx_done, w_flush_take;
  logic [7:0]            w_din, w_sdout, w_ovf;
  logic [ADDR_W-1:0]     w_addr;
  logic [DEPTH_LOG2-1:0] w_wr_ptr, w_rd_ptr;
  logic [DEPTH_LOG2:0]   w_count;
  logic                  w_flush_req, w_tx_pend;

  assign w_flush_req = r_flush_pend | flush;

  // Strobes and addresses are registered: the comb block decodes the values
  // that must be on the pins during the state being entered.
  always_comb begin
    w_next       = r_state;
    w_cs         = 1'b0;
    w_we         = 1'b0;
    w_rs         = r_acia_rs;
    w_din        = r_acia_din;
    w_swe        = 1'b0;
    w_addr       = r_sram_addr;
    w_sdout      = r_sram_dout;
    w_wr_ptr     = r_wr_ptr;
    w_rd_ptr     = r_rd_ptr;
    w_count      = r_count;
    w_ovf        = r_ovf;
    w_tx_done    = 1'b0;
    w_flush_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_ST_RD;
        w_cs   = 1'b1;
        w_rs   = 1'b0;
        if (w_flush_req) begin
          w_wr_ptr     = '0;
          w_rd_ptr     = '0;
          w_count      = '0;
          w_flush_take = 1'b1;
        end
      end
      S_ST_RD: w_next = S_ST_WAIT;
      S_ST_WAIT: begin
        if (acia_dout[0]) begin
          w_next = S_RX_RD;
          w_cs   = 1'b1;
          w_rs   = 1'b1;
        end else if (acia_dout[1] && tx_en && w_tx_pend && !r_empty) begin
          w_next = S_M_RD;
          w_addr = BASE | ADDR_W'(r_rd_ptr);
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RX_RD: w_next = S_RX_WAIT;
      S_RX_WAIT: begin
        w_next = S_RX_WR;
        if (!r_full) begin
          w_swe   = 1'b1;
          w_addr  = BASE | ADDR_W'(r_wr_ptr);
          w_sdout = acia_dout;
        end
      end
      S_RX_WR: begin
        w_next = S_IDLE;
        if (!r_full) begin
          w_wr_ptr = r_wr_ptr + 1'b1;
          w_count  = r_count + 1'b1;
        end else if (r_ovf != 8'hFF) begin
          w_ovf = r_ovf + 8'd1;
        end
      end
      S_M_RD: w_next = S_M_WAIT;
      S_M_WAIT: begin
        w_next = S_TX_WR;
        w_cs   = 1'b1;
        w_we   = 1'b1;
        w_rs   = 1'b1;
        w_din  = sram_din;
      end
      S_TX_WR: begin
        w_next    = S_IDLE;
        w_rd_ptr  = r_rd_ptr + 1'b1;
        w_count   = r_count - 1'b1;
        w_tx_done = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_acia_cs    <= 1'b0;
      r_acia_we    <= 1'b0;
      r_acia_rs    <= 1'b0;
      r_acia_din   <= 8'h00;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= BASE;
      r_sram_dout  <= 8'h00;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_ovf        <= 8'h00;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_acia_cs    <= w_cs;
      r_acia_we    <= w_we;
      r_acia_rs    <= w_rs;
      r_acia_din   <= w_din;
      r_sram_we    <= w_swe;
      r_sram_addr  <= w_addr;
      r_sram_dout  <= w_sdout;
      r_wr_ptr     <= w_wr_ptr;
      r_rd_ptr     <= w_rd_ptr;
      r_count      <= w_count;
      r_full       <= (w_count == c_DEPTH);
      r_empty      <= (w_count == '0);
      r_ovf        <= w_ovf;
      r_flush_pend <= w_flush_take ? 1'b0 : w_flush_req;
    end
  end

  generate
    if (TX_PERIOD_LOG2 == 0) begin : g_nopace
      assign w_tx_pend = 1'b1;
    end else begin : g_pace
      logic [TX_PERIOD_LOG2-1:0] r_pace;
      logic                      r_tx_pend;
      // A wrap arriving in the same clk as a TX completion re-arms the next byte.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pace    <= '0;
          r_tx_pend <= 1'b0;
        end else begin
          r_pace <= r_pace + 1'b1;
          if (&r_pace)
            r_tx_pend <= 1'b1;
          else if (w_tx_done)
            r_tx_pend <= 1'b0;
        end
      end
      assign w_tx_pend = r_tx_pend;
    end
  endgenerate

  assign acia_cs   = r_acia_cs;
  assign acia_we   = r_acia_we;
  assign acia_rs   = r_acia_rs;
  assign acia_din  = r_acia_din;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign sram_dout = r_sram_dout;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign ovf_cnt   = r_ovf;

endmodule
`default_nettype wire
